// File: rtl/mac_requant.sv
// mac_requant: accumulates LEN signed MAC sums, then rounds, shifts and saturates.
// Optional build macro MAC_REQUANT_RELU_EN clamps negative results to zero.
module mac_requant #(
    parameter int CP    = 16,
    parameter int OP    = 8,
    parameter int LEN   = 16,
    parameter int SHIFT = 7,
    parameter int ACC_W = 21
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [CP:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [OP:0] out_data,
    output logic               out_sat,
    output logic               busy
);

    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);
    localparam logic signed [ACC_W:0] RND  = ((ACC_W+1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << OP) - 1);
    localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-(1 << OP));

    typedef enum logic [1:0] {
        ACCUM,
        ROUND,
        HOLD
    } state_t;

    state_t state, state_nx;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] ext;
    logic [CW-1:0]           count;
    logic                    accept;
    logic signed [ACC_W:0]   rsum;
    logic signed [ACC_W:0]   r;
    logic signed [OP:0]      q;
    logic                    hi;
    logic                    lo;
    logic                    sat;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign ext      = ACC_W'(in_data);
    assign busy     = (count != '0) || (state != ACCUM);

    // Round half-up at one extra bit, shift, then clamp to the output range.
    always_comb begin
        rsum = {acc[ACC_W-1], acc} + RND;
        r    = rsum >>> SHIFT;
        hi   = (r > MAXV);
        lo   = (r < MINV);
        q    = r[OP:0];
        sat  = hi || lo;
        if (hi) begin
            q = MAXV[OP:0];
        end else if (lo) begin
            q = MINV[OP:0];
        end
`ifdef MAC_REQUANT_RELU_EN
        if (q[OP]) begin
            q = '0;
        end
        sat = hi;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: accumulate LEN beats, one rounding cycle, hold until taken.
    always_comb begin
        state_nx = state;
        unique case (state)
            ACCUM: begin
                if (accept && (count == LAST)) begin
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                state_nx = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_nx = ACCUM;
                end
            end
            default: begin
                state_nx = ACCUM;
            end
        endcase
    end

    // Datapath: accumulator, beat counter and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        acc   <= acc + ext;
                        count <= count + 1'b1;
                    end
                end
                ROUND: begin
                    out_data  <= q;
                    out_sat   <= sat;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_requant.sv
// tb_mac_requant: randomized and directed checks of mac_requant at LEN=4, SHIFT=7.
// Expected results come from an integer model of round/shift/saturate.
module tb_mac_requant;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [16:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [8:0]  out_data;
    logic               out_sat;
    logic               busy;

    int tests;
    int fails;

    mac_requant #(
        .CP(16), .OP(8), .LEN(4), .SHIFT(7), .ACC_W(21)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sat(out_sat),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input int v[4], output int d, output bit s);
        longint sum;
        longint n;
        longint qq;
        sum = 0;
        for (int i = 0; i < 4; i++) sum += v[i];
        n = sum + 64;
        if (n >= 0) qq = n / 128;
        else qq = -((-n + 127) / 128);
        s = 1'b0;
        if (qq > 255) begin
            qq = 255;
            s = 1'b1;
        end else if (qq < -256) begin
            qq = -256;
            s = 1'b1;
        end
`ifdef MAC_REQUANT_RELU_EN
        if (qq < 0) begin
            qq = 0;
            s = 1'b0;
        end
`endif
        d = int'(qq);
    endfunction

    task automatic send_beats(input int v[4], input bit gaps, output bit to);
        int g;
        to = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data = 17'(v[i]);
            g = 0;
            while (!in_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) to = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = 17'($urandom);
    endtask

    task automatic recv(input int bp, output logic signed [8:0] d,
                        output logic s, output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d = out_data;
        s = out_sat;
        repeat (bp) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #12;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        tests++;
        if (out_data !== 9'sd0 || out_sat !== 1'b0) begin
            fails++;
            $display("FAIL reset_out got %0d/%b want 0/0", out_data, out_sat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        int v[4] = '{64, 64, 64, 64};
        bit to;
        out_ready = 1'b1;
        send_beats(v, 1'b0, to);
        tests++;
        if (to || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_round_cycle got v=%b r=%b to=%b want 0 0 0",
                     out_valid, in_ready, to);
        end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_latency got v=%b r=%b want 1 0",
                     out_valid, in_ready);
        end
        tests++;
        if (out_data !== 9'sd2 || out_sat !== 1'b0) begin
            fails++;
            $display("FAIL basic_data got %0d/%b want 2/0", out_data, out_sat);
        end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_release got v=%b r=%b b=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_rounding;
        int ins[4] = '{64, -64, -65, 63};
        int exp_d[4];
        logic signed [8:0] d;
        logic s;
        int lat;
        bit to;
        exp_d = '{1, 0, -1, 0};
`ifdef MAC_REQUANT_RELU_EN
        exp_d[2] = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            int v[4];
            v = '{ins[k], 0, 0, 0};
            send_beats(v, 1'b0, to);
            recv(0, d, s, lat);
            tests++;
            if (to || lat != 1 || d !== 9'(exp_d[k]) || s !== 1'b0) begin
                fails++;
                $display("FAIL rounding_%0d got %0d/%b lat=%0d want %0d/0 lat=1",
                         ins[k], d, s, lat, exp_d[k]);
            end
        end
    endtask

    task automatic test_saturation;
        int v[4];
        logic signed [8:0] d;
        logic s;
        int lat;
        bit to;
        int ed;
        bit es;
        v = '{65535, 65535, 65535, 65535};
        send_beats(v, 1'b0, to);
        recv(0, d, s, lat);
        tests++;
        if (to || d !== 9'sd255 || s !== 1'b1) begin
            fails++;
            $display("FAIL sat_high got %0d/%b want 255/1", d, s);
        end
        v = '{-65536, -65536, -65536, -65536};
        ed = -256;
        es = 1'b1;
`ifdef MAC_REQUANT_RELU_EN
        ed = 0;
        es = 1'b0;
`endif
        send_beats(v, 1'b0, to);
        recv(0, d, s, lat);
        tests++;
        if (to || d !== 9'(ed) || s !== es) begin
            fails++;
            $display("FAIL sat_low got %0d/%b want %0d/%b", d, s, ed, es);
        end
    endtask

    task automatic test_backpressure;
        int v[4];
        logic signed [8:0] d0;
        logic s0;
        logic signed [8:0] d;
        logic s;
        int lat;
        bit to;
        bit bad;
        v = '{100, 200, 300, 400};
        out_ready = 1'b0;
        send_beats(v, 1'b0, to);
        @(posedge clk);
        #1;
        d0 = out_data;
        s0 = out_sat;
        tests++;
        if (to || out_valid !== 1'b1 || d0 !== 9'sd8 || s0 !== 1'b0) begin
            fails++;
            $display("FAIL bp_first got %0d/%b v=%b want 8/0 v=1",
                     d0, s0, out_valid);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 17'($urandom);
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== d0 || out_sat !== s0 ||
                in_ready !== 1'b0) bad = 1'b1;
        end
        in_valid = 1'b0;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL bp_hold got %0d/%b v=%b r=%b want %0d/%b v=1 r=0",
                     out_data, out_sat, out_valid, in_ready, d0, s0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_handshake got v=%b b=%b want 0 0", out_valid, busy);
        end
        v = '{128, 128, 128, 128};
        send_beats(v, 1'b0, to);
        recv(0, d, s, lat);
        tests++;
        if (to || d !== 9'sd4 || s !== 1'b0) begin
            fails++;
            $display("FAIL bp_next_group got %0d/%b want 4/0", d, s);
        end
    endtask

    task automatic test_reset_mid;
        int v[4];
        logic signed [8:0] d;
        logic s;
        int lat;
        bit to;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 17'sd5000;
        @(negedge clk);
        in_data = 17'sd5000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_busy_before got %b want 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got v=%b b=%b want 0 0", out_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        v = '{128, 128, 128, 128};
        send_beats(v, 1'b0, to);
        recv(0, d, s, lat);
        tests++;
        if (to || d !== 9'sd4 || s !== 1'b0) begin
            fails++;
            $display("FAIL mid_after got %0d/%b want 4/0", d, s);
        end
    endtask

    task automatic test_random;
        int v[4];
        int ed;
        bit es;
        logic signed [8:0] d;
        logic s;
        int lat;
        bit to;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (n < 15) v[i] = int'($urandom_range(0, 131071)) - 65536;
                else v[i] = int'($urandom_range(0, 8191)) - 4096;
            end
            model(v, ed, es);
            send_beats(v, 1'b1, to);
            recv(int'($urandom_range(0, 3)), d, s, lat);
            tests++;
            if (to || lat != 1 || d !== 9'(ed) || s !== es) begin
                fails++;
                $display("FAIL random_%0d got %0d/%b lat=%0d want %0d/%b",
                         n, d, s, lat, ed, es);
            end
        end
    endtask

    task automatic test_relu;
`ifdef MAC_REQUANT_RELU_EN
        int v[4];
        logic signed [8:0] d;
        logic s;
        int lat;
        bit to;
        v = '{-1000, -1000, -1000, -1000};
        send_beats(v, 1'b0, to);
        recv(0, d, s, lat);
        tests++;
        if (to || d !== 9'sd0 || s !== 1'b0) begin
            fails++;
            $display("FAIL relu_neg got %0d/%b want 0/0", d, s);
        end
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_relu();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
